// File: rtl/config_bitstream_loader.sv
// Tile configuration bus transmitter: parses a header-checked frame of address/data
// word pairs from a valid/ready stream and broadcasts them as one-cycle config writes.
module config_bitstream_loader #(
  parameter logic [15:0] MAGIC     = 16'hC0DE,
  parameter int unsigned WRITE_GAP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] bs_data,
  input  logic        bs_valid,
  output logic        bs_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_write,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written,
  output logic [2:0]  dbg_state
);

  // Handshake: a word moves only on a rising edge where bs_valid && bs_ready;
  // bs_ready is decoded from the registered state and never looks at bs_valid.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_GAP    = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam bit          HAS_GAP  = (WRITE_GAP != 0);
  localparam logic [15:0] GAP_LOAD = HAS_GAP ? 16'(WRITE_GAP - 1) : 16'd0;

  state_t      state, state_next;
  logic [15:0] remaining;
  logic [15:0] gap_cnt;
  logic [31:0] addr_hold;
  logic        magic_ok;

  assign magic_ok  = (bs_data[31:16] == MAGIC);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bs_ready     = 1'b0;
    config_write = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_next = S_HEADER;
      S_HEADER: begin
        bs_ready = 1'b1;
        busy     = 1'b1;
        if (bs_valid) begin
          if (!magic_ok)                  state_next = S_ERROR;
          else if (bs_data[15:0] == 16'd0) state_next = S_DONE;
          else                             state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        bs_ready = 1'b1;
        busy     = 1'b1;
        if (bs_valid) state_next = S_DATA;
      end
      S_DATA: begin
        bs_ready = 1'b1;
        busy     = 1'b1;
        if (bs_valid) state_next = S_WRITE;
      end
      S_WRITE: begin
        config_write = 1'b1;
        busy         = 1'b1;
        // remaining still holds the pre-decrement count here
        if (HAS_GAP)                 state_next = S_GAP;
        else if (remaining != 16'd1) state_next = S_ADDR;
        else                         state_next = S_DONE;
      end
      S_GAP: begin
        busy = 1'b1;
        if (gap_cnt == 16'd0) state_next = (remaining != 16'd0) ? S_ADDR : S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) state_next = S_HEADER;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining     <= 16'd0;
      gap_cnt       <= 16'd0;
      addr_hold     <= 32'd0;
      config_addr   <= 32'd0;
      config_data   <= 32'd0;
      words_written <= 16'd0;
    end else begin
      unique case (state)
        S_IDLE, S_ERROR: if (start) words_written <= 16'd0;
        S_HEADER: if (bs_valid && magic_ok) remaining <= bs_data[15:0];
        S_ADDR:   if (bs_valid) addr_hold <= bs_data;
        S_DATA: begin
          if (bs_valid) begin
            config_addr <= addr_hold;
            config_data <= bs_data;
          end
        end
        S_WRITE: begin
          words_written <= words_written + 16'd1;
          remaining     <= remaining - 16'd1;
          gap_cnt       <= GAP_LOAD;
        end
        S_GAP: if (gap_cnt != 16'd0) gap_cnt <= gap_cnt - 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_bitstream_loader.sv
// Directed bench for config_bitstream_loader: one instance with WRITE_GAP=1 and one
// with WRITE_GAP=0, driven independently, with a write-pair scoreboard per instance.
module tb_config_bitstream_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] bs_data;
  logic        start_1, valid_1, start_0, valid_0;

  logic        rdy_1, cw_1, busy_1, done_1, err_1;
  logic [31:0] addr_1, data_1;
  logic [15:0] ww_1;
  logic [2:0]  st_1;
  logic        rdy_0, cw_0, busy_0, done_0, err_0;
  logic [31:0] addr_0, data_0;
  logic [15:0] ww_0;
  logic [2:0]  st_0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wcnt1    = 0;
  int wcnt0    = 0;
  logic [63:0] exp1_q[$];
  logic [63:0] exp0_q[$];
  int          wr0_cyc[$];

  always #5 clk = ~clk;

  config_bitstream_loader #(.MAGIC(16'hC0DE), .WRITE_GAP(1)) u_dut (
    .clk(clk), .reset(reset), .start(start_1), .bs_data(bs_data), .bs_valid(valid_1),
    .bs_ready(rdy_1), .config_addr(addr_1), .config_data(data_1), .config_write(cw_1),
    .busy(busy_1), .done(done_1), .error(err_1), .words_written(ww_1), .dbg_state(st_1)
  );

  config_bitstream_loader #(.MAGIC(16'hC0DE), .WRITE_GAP(0)) u_dut_g0 (
    .clk(clk), .reset(reset), .start(start_0), .bs_data(bs_data), .bs_valid(valid_0),
    .bs_ready(rdy_0), .config_addr(addr_0), .config_data(data_0), .config_write(cw_0),
    .busy(busy_0), .done(done_0), .error(err_0), .words_written(ww_0), .dbg_state(st_0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboards: every write strobe must match the next expected pair.
  initial forever begin
    @(negedge clk);
    if (reset && cw_1) begin
      wcnt1++;
      if (exp1_q.size() == 0) check("wr1_unexpected", {addr_1, data_1}, 64'd0);
      else check("wr1_pair", {addr_1, data_1}, exp1_q.pop_front());
    end
    if (reset && cw_0) begin
      wcnt0++;
      wr0_cyc.push_back(cyc);
      if (exp0_q.size() == 0) check("wr0_unexpected", {addr_0, data_0}, 64'd0);
      else check("wr0_pair", {addr_0, data_0}, exp0_q.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit g0);
    if (g0) start_0 = 1'b1; else start_1 = 1'b1;
    @(posedge clk);
    #1;
    start_0 = 1'b0;
    start_1 = 1'b0;
  endtask

  task automatic send_word(input bit g0, input logic [31:0] w);
    int n;
    bs_data = w;
    if (g0) valid_0 = 1'b1; else valid_1 = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if ((g0 ? rdy_0 : rdy_1) === 1'b1) break;
      n++;
      if (n >= 100) begin
        check("ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    valid_0 = 1'b0;
    valid_1 = 1'b0;
  endtask

  task automatic wait_done(input bit g0);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if ((g0 ? done_0 : done_1) === 1'b1) break;
      n++;
      if (n >= 200) begin
        check("done_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  logic [31:0] a_tab[3] = '{32'h00020010, 32'h00020011, 32'h00070003};
  logic [31:0] d_tab[3] = '{32'h11111111, 32'hA5A5A5A5, 32'h0BADF00D};

  initial begin
    int base;
    reset   = 1'b0;
    start_1 = 1'b0; valid_1 = 1'b0;
    start_0 = 1'b0; valid_0 = 1'b0;
    bs_data = 32'd0;
    idle(3);

    // Reset state
    check("rst_outs", {rdy_1, cw_1, busy_1, done_1, err_1}, 64'd0);
    check("rst_addr_data", {addr_1, data_1}, 64'd0);
    check("rst_words", {ww_1, ww_0}, 64'd0);
    reset = 1'b1;
    idle(2);

    // Test 1: single write, WRITE_GAP=1
    base = wcnt1;
    exp1_q.push_back({32'h00010002, 32'hDEADBEEF});
    pulse_start(0);
    check("t1_busy_ready", {busy_1, rdy_1}, 64'b11);
    send_word(0, 32'hC0DE0001);
    send_word(0, 32'h00010002);
    send_word(0, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_write", {cw_1, rdy_1, done_1, ww_1}, {1'b1, 1'b0, 1'b0, 16'd0});
    check("t1_pair", {addr_1, data_1}, {32'h00010002, 32'hDEADBEEF});
    @(negedge clk);
    check("t1_gap", {cw_1, done_1, busy_1, ww_1}, {1'b0, 1'b0, 1'b1, 16'd1});
    @(negedge clk);
    check("t1_done", {done_1, busy_1}, 64'b11);
    @(negedge clk);
    check("t1_idle", {done_1, busy_1, ww_1}, {1'b0, 1'b0, 16'd1});
    check("t1_retain", {addr_1, data_1}, {32'h00010002, 32'hDEADBEEF});
    check("t1_count", 64'(wcnt1 - base), 64'd1);

    // Test 2: three writes with stalls before each data word
    base = wcnt1;
    for (int i = 0; i < 3; i++) exp1_q.push_back({a_tab[i], d_tab[i]});
    pulse_start(0);
    check("t2_words_clr", 64'(ww_1), 64'd0);
    send_word(0, 32'hC0DE0003);
    for (int i = 0; i < 3; i++) begin
      send_word(0, a_tab[i]);
      idle(4);
      check("t2_stall_hold", {rdy_1, cw_1}, 64'b10);
      send_word(0, d_tab[i]);
    end
    wait_done(0);
    check("t2_words", 64'(ww_1), 64'd3);
    check("t2_count", 64'(wcnt1 - base), 64'd3);
    check("t2_q_empty", 64'(exp1_q.size()), 64'd0);
    idle(2);

    // Test 3: bad header, then recovery with an empty frame
    base = wcnt1;
    pulse_start(0);
    send_word(0, 32'hBEEF0005);
    @(negedge clk);
    check("t3_error", {err_1, busy_1, rdy_1, cw_1}, 64'b1000);
    bs_data = 32'hC0DE0001;
    valid_1 = 1'b1;
    idle(3);
    valid_1 = 1'b0;
    @(negedge clk);
    check("t3_sticky", {err_1, busy_1, rdy_1}, 64'b100);
    check("t3_no_write", 64'(wcnt1 - base), 64'd0);
    pulse_start(0);
    check("t3_restart", {err_1, busy_1, rdy_1}, 64'b011);
    send_word(0, 32'hC0DE0000);
    @(negedge clk);
    check("t3_done", {done_1, busy_1, err_1, ww_1}, {1'b1, 1'b1, 1'b0, 16'd0});
    @(negedge clk);
    check("t3_idle", {done_1, busy_1}, 64'd0);

    // Test 4: asynchronous reset while in WRITE
    pulse_start(0);
    send_word(0, 32'hC0DE0002);
    send_word(0, 32'h00030004);
    send_word(0, 32'h55AA55AA);
    #1;
    check("t4_in_write", 64'(cw_1), 64'd1);
    reset = 1'b0;
    #1;
    check("t4_async_outs", {cw_1, busy_1, rdy_1, done_1, err_1}, 64'd0);
    check("t4_async_pair", {addr_1, data_1}, 64'd0);
    check("t4_async_words", 64'(ww_1), 64'd0);
    #3;
    reset = 1'b1;
    base = wcnt1;
    exp1_q.push_back({32'h00050006, 32'h12345678});
    pulse_start(0);
    send_word(0, 32'hC0DE0001);
    send_word(0, 32'h00050006);
    send_word(0, 32'h12345678);
    wait_done(0);
    check("t4_words", 64'(ww_1), 64'd1);
    check("t4_count", 64'(wcnt1 - base), 64'd1);
    check("t4_q_empty", 64'(exp1_q.size()), 64'd0);
    idle(2);

    // Test 5: WRITE_GAP=0 back-to-back, start held while busy
    base = wcnt0;
    wr0_cyc.delete();
    exp0_q.push_back({32'h000A0001, 32'hCAFE0001});
    exp0_q.push_back({32'h000A0002, 32'hCAFE0002});
    pulse_start(1);
    send_word(1, 32'hC0DE0002);
    start_0 = 1'b1;
    send_word(1, 32'h000A0001);
    send_word(1, 32'hCAFE0001);
    send_word(1, 32'h000A0002);
    send_word(1, 32'hCAFE0002);
    start_0 = 1'b0;
    wait_done(1);
    check("t5_words", 64'(ww_0), 64'd2);
    check("t5_count", 64'(wcnt0 - base), 64'd2);
    check("t5_spacing", (wr0_cyc.size() >= 2) ? 64'(wr0_cyc[1] - wr0_cyc[0]) : 64'd0, 64'd3);
    idle(3);
    @(negedge clk);
    check("t5_idle", {busy_0, done_0, err_0, rdy_0}, 64'd0);
    check("t5_q_empty", 64'(exp0_q.size()), 64'd0);
    check("t5_other_quiet", 64'(ww_1), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/config_bitstream_loader.md
Name: config_bitstream_loader

Overview:
- Transmit side of the tile configuration bus: consumes a packed bitstream from an upstream word stream over a valid/ready handshake.
- Issues one-cycle config writes on config_addr/config_data, which are broadcast to every tile's address matchers.
- Sits at the array top, between the host/ROM stream source and the tile grid.
- Frames are header-checked; write spacing is programmable so slow tiles can latch each write.

Parameters:
MAGIC, 16'hC0DE, required value of header bits [31:16]
WRITE_GAP, 1, idle cycles inserted after each write pulse (0 allowed)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  arms loader for one frame; sampled in IDLE and ERROR only
bs_data  input  32  bitstream word
bs_valid  input  1  bs_data valid
bs_ready  output  1  loader accepts bs_data this cycle
config_addr  output  32  broadcast config address, {tile_id[15:0], config_id[15:0]}
config_data  output  32  broadcast config data
config_write  output  1  one-cycle write strobe to tiles
busy  output  1  frame in progress
done  output  1  one-cycle pulse at frame completion
error  output  1  sticky bad-header flag
words_written  output  16  writes issued in current/last frame

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0, including config_addr/config_data and words_written. Reset mid-frame drops config_write immediately and discards the frame.
- Word transfer occurs only when bs_valid and bs_ready are both 1 at a rising edge.
- bs_ready is 1 only in HEADER, ADDR and DATA, and is decoded from the registered state.
- IDLE:
  - start=1 -> HEADER.
  - On that edge, clear words_written and error, and set busy=1.
- HEADER, on transfer:
  - If bs_data[31:16]==MAGIC, latch remaining=bs_data[15:0].
  - remaining==0 -> DONE; otherwise -> ADDR.
  - If the magic does not match -> ERROR.
- ADDR: on transfer, latch the address word into a holding register -> DATA.
- DATA: on transfer, latch the data word -> WRITE.
- WRITE (exactly one cycle):
  - config_write=1.
  - config_addr/config_data present the latched pair, updated on entry to WRITE.
  - words_written+1 and remaining-1.
  - Next state: GAP if WRITE_GAP>0; else ADDR if remaining after decrement is nonzero; else DONE.
- GAP:
  - config_write=0 for exactly WRITE_GAP cycles.
  - Then ADDR if remaining!=0, else DONE.
- DONE: done=1 for one cycle; busy=0 on the same edge that leaves DONE -> IDLE.
- ERROR:
  - error=1 (sticky), busy=0, bs_ready=0.
  - start=1 -> HEADER, with error cleared on that edge.
- start is ignored while busy. bs_valid is ignored when bs_ready=0.
- config_addr/config_data retain the last written pair after WRITE. Tiles must qualify on config_write only.
- Stalls (bs_valid=0) in HEADER/ADDR/DATA hold state indefinitely; no timeout.
- Write rate limit: minimum of 3+WRITE_GAP cycles per write, given continuous bs_valid.
- remaining and words_written are 16-bit. A header count of 16'hFFFF issues 65535 writes with no wrap before DONE.

Test Plan:
- Single write, WRITE_GAP=1, continuous valid: start; words C0DE0001, 00010002, DEADBEEF -> config_write high for one cycle with addr 00010002 / data DEADBEEF; done pulses 2 cycles later (GAP, then DONE); words_written=1.
- Three writes with bs_valid deasserted 4 cycles before each data word -> exactly 3 config_write pulses with matching pairs, no extra strobes during stalls, words_written=3.
- Header BEEF0005 -> error=1, busy=0, bs_ready=0, no config_write. Then start with C0DE0000 -> error clears, done pulses, words_written=0.
- Assert reset low mid-frame while in WRITE -> config_write, busy and all outputs 0 asynchronously. Release reset and start a fresh frame -> completes normally.
- WRITE_GAP=0, two pairs streamed back-to-back -> write strobes 3 cycles apart; start pulsed while busy has no effect.
